// File: rtl/pacote_rpn.sv
// Shared definitions for the RPN command sequencer: command codes, FSM states
// and default sizes.
package pacote_rpn;

    localparam int LARG_PADRAO   = 8;
    localparam int PROF_PADRAO   = 4;
    localparam int ESPERA_PADRAO = 300;

    // OPCODE bit that selects the multi-cycle (START/Pronto) unit
    localparam int OPC_MULTI = 2;

    localparam logic [2:0] CMD_PUSH  = 3'b000;
    localparam logic [2:0] CMD_DROP  = 3'b001;
    localparam logic [2:0] CMD_DUP   = 3'b010;
    localparam logic [2:0] CMD_SWAP  = 3'b011;
    localparam logic [2:0] CMD_EXEC  = 3'b100;
    localparam logic [2:0] CMD_CLEAR = 3'b101;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        EMITE   = 3'd1,
        GUARDA  = 3'd2,
        ESPERA  = 3'd3,
        ESCREVE = 3'd4
    } estado_t;

endpackage

// File: rtl/sequenciador_rpn_if.sv
// Command channel of the RPN sequencer.
// Handshake: a command transfers on the rising edge where CMD_VALID and
// CMD_READY are both 1; the master holds CMD/OPCODE/DADO_IN stable while
// CMD_VALID is high and waits for CMD_READY.
interface sequenciador_rpn_if #(
    parameter int LARG = pacote_rpn::LARG_PADRAO
) ();
    logic            CMD_VALID;
    logic            CMD_READY;
    logic [2:0]      CMD;
    logic [2:0]      OPCODE;
    logic [LARG-1:0] DADO_IN;

    modport master (output CMD_VALID, output CMD, output OPCODE, output DADO_IN,
                    input  CMD_READY);
    modport slave  (input  CMD_VALID, input  CMD, input  OPCODE, input  DADO_IN,
                    output CMD_READY);
endinterface

// File: rtl/pilha_rpn.sv
// Register operand stack; entry 0 is always the top, so every operation is a
// fixed shift and no entry is addressed through the level counter.
module pilha_rpn
    import pacote_rpn::*;
#(
    parameter int LARG = LARG_PADRAO,
    parameter int PROF = PROF_PADRAO
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       pop2push,
    input  logic                       dup,
    input  logic                       swap,
    input  logic                       clear,
    input  logic [LARG-1:0]            din,
    input  logic [LARG-1:0]            res,
    output logic [$clog2(PROF+1)-1:0]  nivel,
    output logic [LARG-1:0]            topo,
    output logic [LARG-1:0]            nos
);
    localparam int NW = $clog2(PROF + 1);

    logic [LARG-1:0] mem   [PROF];
    logic [LARG-1:0] mem_n [PROF];
    logic [NW-1:0]   nivel_n;

    always_comb begin
        mem_n   = mem;
        nivel_n = nivel;
        if (clear) begin
            for (int i = 0; i < PROF; i++) mem_n[i] = '0;
            nivel_n = '0;
        end else if (push || dup) begin
            for (int i = PROF - 1; i > 0; i--) mem_n[i] = mem[i-1];
            mem_n[0] = push ? din : mem[0];
            nivel_n  = nivel + 1'b1;
        end else if (pop) begin
            for (int i = 1; i < PROF; i++) mem_n[i-1] = mem[i];
            mem_n[PROF-1] = '0;
            nivel_n       = nivel - 1'b1;
        end else if (pop2push) begin
            // TOS and NOS are consumed, the result becomes the new TOS
            for (int i = 0; i < PROF; i++) mem_n[i] = '0;
            for (int i = 2; i < PROF; i++) mem_n[i-1] = mem[i];
            mem_n[0] = res;
            nivel_n  = nivel - 1'b1;
        end else if (swap) begin
            mem_n[0] = mem[1];
            mem_n[1] = mem[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PROF; i++) mem[i] <= '0;
            nivel <= '0;
        end else begin
            mem   <= mem_n;
            nivel <= nivel_n;
        end
    end

    assign topo = (nivel == '0) ? '0 : mem[0];
    assign nos  = mem[1];

endmodule

// File: rtl/sequenciador_rpn.sv
// RPN command sequencer: decodes stack commands and sequences binary operations
// on the shared arithmetic unit, with a guard cycle and watchdog for multi-cycle ops.
module sequenciador_rpn
    import pacote_rpn::*;
#(
    parameter int LARG       = LARG_PADRAO,
    parameter int PROF       = PROF_PADRAO,
    parameter int MAX_ESPERA = ESPERA_PADRAO
) (
    input  logic                       CLOCK,
    input  logic                       RESET,
    sequenciador_rpn_if.slave          cmd_if,
    output logic [LARG-1:0]            ULA_A,
    output logic [LARG-1:0]            ULA_B,
    output logic [2:0]                 ULA_OP,
    output logic                       ULA_START,
    input  logic                       ULA_PRONTO,
    input  logic [LARG-1:0]            ULA_RES,
    input  logic                       ULA_OV,
    output logic [LARG-1:0]            TOPO,
    output logic [$clog2(PROF+1)-1:0]  NIVEL,
    output logic                       FLAG_OV,
    output logic                       ERRO_VAZIO,
    output logic                       ERRO_CHEIO,
    output logic                       ERRO_TEMPO,
    output estado_t                    estado_dbg
);
    localparam int NW = $clog2(PROF + 1);
    localparam int WW = $clog2(MAX_ESPERA + 1);

    estado_t       estado, prox_estado;
    logic [WW-1:0] wd;
    logic          wd_fim;
    logic          vazia, cheia, dois;
    logic          cmd_pronto;
    logic          empilha, desempilha, duplica, troca, limpa, escreve;
    logic          trava_op, set_vazio, set_cheio, set_tempo;

    assign vazia  = (NIVEL == '0);
    assign cheia  = (NIVEL == NW'(PROF));
    assign dois   = (NIVEL >= NW'(2));
    assign wd_fim = (wd == WW'(MAX_ESPERA - 1));

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) estado <= OCIOSO;
        else        estado <= prox_estado;
    end

    always_comb begin
        prox_estado = estado;
        case (estado)
            OCIOSO:  if (cmd_if.CMD_VALID && cmd_if.CMD == CMD_EXEC && dois)
                         prox_estado = EMITE;
            EMITE:   prox_estado = ULA_OP[OPC_MULTI] ? GUARDA : ESCREVE;
            // Pronto is not trusted until the unit has seen START for a cycle
            GUARDA:  prox_estado = ESPERA;
            ESPERA:  if (ULA_PRONTO)  prox_estado = ESCREVE;
                     else if (wd_fim) prox_estado = OCIOSO;
            ESCREVE: prox_estado = OCIOSO;
            default: prox_estado = OCIOSO;
        endcase
    end

    always_comb begin
        cmd_pronto = 1'b0;
        empilha    = 1'b0;
        desempilha = 1'b0;
        duplica    = 1'b0;
        troca      = 1'b0;
        limpa      = 1'b0;
        escreve    = 1'b0;
        trava_op   = 1'b0;
        set_vazio  = 1'b0;
        set_cheio  = 1'b0;
        set_tempo  = 1'b0;
        ULA_START  = 1'b0;
        case (estado)
            OCIOSO: begin
                cmd_pronto = 1'b1;
                if (cmd_if.CMD_VALID) begin
                    case (cmd_if.CMD)
                        CMD_PUSH:  if (cheia) set_cheio = 1'b1; else empilha = 1'b1;
                        CMD_DROP:  if (vazia) set_vazio = 1'b1; else desempilha = 1'b1;
                        CMD_DUP: begin
                            if (vazia)      set_vazio = 1'b1;
                            else if (cheia) set_cheio = 1'b1;
                            else            duplica   = 1'b1;
                        end
                        CMD_SWAP:  if (!dois) set_vazio = 1'b1; else troca    = 1'b1;
                        CMD_EXEC:  if (!dois) set_vazio = 1'b1; else trava_op = 1'b1;
                        CMD_CLEAR: limpa = 1'b1;
                        default: ;
                    endcase
                end
            end
            EMITE:   ULA_START = ULA_OP[OPC_MULTI];
            ESPERA:  set_tempo = !ULA_PRONTO && wd_fim;
            ESCREVE: escreve   = 1'b1;
            default: ;
        endcase
    end

    assign cmd_if.CMD_READY = cmd_pronto;
    assign estado_dbg       = estado;

    // Counts ESPERA cycles; restarts whenever the FSM is elsewhere
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET)                wd <= '0;
        else if (estado != ESPERA) wd <= '0;
        else                       wd <= wd + 1'b1;
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET)        ULA_OP <= 3'b000;
        else if (trava_op) ULA_OP <= cmd_if.OPCODE;
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            FLAG_OV    <= 1'b0;
            ERRO_VAZIO <= 1'b0;
            ERRO_CHEIO <= 1'b0;
            ERRO_TEMPO <= 1'b0;
        end else if (limpa) begin
            FLAG_OV    <= 1'b0;
            ERRO_VAZIO <= 1'b0;
            ERRO_CHEIO <= 1'b0;
            ERRO_TEMPO <= 1'b0;
        end else begin
            if (escreve) FLAG_OV <= ULA_OV;
            ERRO_VAZIO <= ERRO_VAZIO | set_vazio;
            ERRO_CHEIO <= ERRO_CHEIO | set_cheio;
            ERRO_TEMPO <= ERRO_TEMPO | set_tempo;
        end
    end

    pilha_rpn #(
        .LARG (LARG),
        .PROF (PROF)
    ) u_pilha (
        .clk      (CLOCK),
        .rst_n    (RESET),
        .push     (empilha),
        .pop      (desempilha),
        .pop2push (escreve),
        .dup      (duplica),
        .swap     (troca),
        .clear    (limpa),
        .din      (cmd_if.DADO_IN),
        .res      (ULA_RES),
        .nivel    (NIVEL),
        .topo     (TOPO),
        .nos      (ULA_A)
    );

    // Stack is frozen while busy, so both operands hold from EMITE to ESCREVE
    assign ULA_B = TOPO;

endmodule

// File: tb/tb_sequenciador_rpn.sv
// Directed bench for sequenciador_rpn with a stub multi-cycle arithmetic unit.
module tb_sequenciador_rpn;
    import pacote_rpn::*;

    localparam int STUB_DELAY = 11;

    logic       CLOCK;
    logic       RESET;
    logic [7:0] ULA_A, ULA_B, ULA_RES, TOPO;
    logic [2:0] ULA_OP, NIVEL;
    logic       ULA_START, ULA_PRONTO, ULA_OV;
    logic       FLAG_OV, ERRO_VAZIO, ERRO_CHEIO, ERRO_TEMPO;
    estado_t    estado_dbg;

    int total = 0;
    int bad   = 0;
    int low_cnt   = 0;
    int start_cnt = 0;
    int stub_modo = 0;  // 0: delayed Pronto, 1: always high, 2: never

    logic stub_busy, stub_pronto;
    int   stub_cnt;

    sequenciador_rpn_if #(.LARG(8)) cmd_if ();

    sequenciador_rpn #(.LARG(8), .PROF(4), .MAX_ESPERA(300)) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .cmd_if     (cmd_if),
        .ULA_A      (ULA_A),
        .ULA_B      (ULA_B),
        .ULA_OP     (ULA_OP),
        .ULA_START  (ULA_START),
        .ULA_PRONTO (ULA_PRONTO),
        .ULA_RES    (ULA_RES),
        .ULA_OV     (ULA_OV),
        .TOPO       (TOPO),
        .NIVEL      (NIVEL),
        .FLAG_OV    (FLAG_OV),
        .ERRO_VAZIO (ERRO_VAZIO),
        .ERRO_CHEIO (ERRO_CHEIO),
        .ERRO_TEMPO (ERRO_TEMPO),
        .estado_dbg (estado_dbg)
    );

    // clock / reset
    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Stub unit: Pronto rises on the 12th edge after the EMITE cycle that carried START
    always @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            stub_busy   <= 1'b0;
            stub_cnt    <= 0;
            stub_pronto <= 1'b0;
        end else if (ULA_START) begin
            stub_busy   <= 1'b1;
            stub_cnt    <= 0;
            stub_pronto <= 1'b0;
        end else if (stub_busy) begin
            stub_cnt <= stub_cnt + 1;
            if (stub_cnt + 1 == STUB_DELAY) stub_pronto <= 1'b1;
        end
    end
    assign ULA_PRONTO = (stub_modo == 1) ? 1'b1 : (stub_modo == 2) ? 1'b0 : stub_pronto;

    always @(negedge CLOCK) begin
        if (!cmd_if.CMD_READY) low_cnt++;
        if (ULA_START) start_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_cmd(input logic [2:0] c, input logic [2:0] op, input logic [7:0] d);
        int n;
        n = 0;
        @(negedge CLOCK);
        while (!cmd_if.CMD_READY && n < 400) begin
            @(negedge CLOCK);
            n++;
        end
        if (n >= 400) check_eq("cmd_ready_wait", 32'(cmd_if.CMD_READY), 1);
        cmd_if.CMD       = c;
        cmd_if.OPCODE    = op;
        cmd_if.DADO_IN   = d;
        cmd_if.CMD_VALID = 1'b1;
        @(posedge CLOCK);
        #1;
        cmd_if.CMD_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge CLOCK);
        while (!cmd_if.CMD_READY && n < 400) begin
            @(negedge CLOCK);
            n++;
        end
        if (n >= 400) check_eq("idle_wait", 32'(cmd_if.CMD_READY), 1);
    endtask

    task automatic cmd_wait(input logic [2:0] c, input logic [7:0] d);
        do_cmd(c, 3'b000, d);
        wait_idle();
    endtask

    task automatic run_exec(input string tag, input logic [2:0] op,
                            input int exp_low, input int exp_start);
        int low0, start0;
        low0   = low_cnt;
        start0 = start_cnt;
        do_cmd(CMD_EXEC, op, 8'd0);
        wait_idle();
        check_eq({tag, "_ready_low"}, 32'(low_cnt - low0), 32'(exp_low));
        check_eq({tag, "_start"}, 32'(start_cnt - start0), 32'(exp_start));
    endtask

    initial begin
        int n;
        RESET            = 1'b0;
        cmd_if.CMD_VALID = 1'b0;
        cmd_if.CMD       = 3'b111;
        cmd_if.OPCODE    = 3'b000;
        cmd_if.DADO_IN   = 8'd0;
        ULA_RES          = 8'd0;
        ULA_OV           = 1'b0;
        repeat (3) @(negedge CLOCK);
        check_eq("rst_nivel", 32'(NIVEL), 0);
        check_eq("rst_topo", 32'(TOPO), 0);
        check_eq("rst_ready", 32'(cmd_if.CMD_READY), 1);
        check_eq("rst_start", 32'(ULA_START), 0);
        check_eq("rst_op", 32'(ULA_OP), 0);
        check_eq("rst_flags", {28'd0, FLAG_OV, ERRO_VAZIO, ERRO_CHEIO, ERRO_TEMPO}, 0);
        check_eq("rst_estado", 32'(estado_dbg), 32'(OCIOSO));
        RESET = 1'b1;

        // multi-cycle EXEC: 11 ESPERA cycles, READY low for 14
        cmd_wait(CMD_PUSH, 8'd7);
        cmd_wait(CMD_PUSH, 8'd9);
        check_eq("push_topo", 32'(TOPO), 9);
        check_eq("push_nivel", 32'(NIVEL), 2);
        check_eq("ula_a", 32'(ULA_A), 7);
        check_eq("ula_b", 32'(ULA_B), 9);
        stub_modo = 0; ULA_RES = 8'd63; ULA_OV = 1'b0;
        run_exec("mul1", 3'b100, 14, 1);
        check_eq("mul1_topo", 32'(TOPO), 63);
        check_eq("mul1_nivel", 32'(NIVEL), 1);
        check_eq("mul1_ov", 32'(FLAG_OV), 0);
        check_eq("mul1_op", 32'(ULA_OP), 4);

        // single-cycle EXEC
        cmd_wait(CMD_PUSH, 8'd2);
        ULA_RES = 8'd65;
        run_exec("add", 3'b001, 2, 0);
        check_eq("add_topo", 32'(TOPO), 65);
        check_eq("add_nivel", 32'(NIVEL), 1);

        // saturating result with overflow, then CLEAR
        cmd_wait(CMD_PUSH, 8'd20);
        cmd_wait(CMD_PUSH, 8'd20);
        ULA_RES = 8'd255; ULA_OV = 1'b1;
        run_exec("mul2", 3'b100, 14, 1);
        check_eq("mul2_topo", 32'(TOPO), 255);
        check_eq("mul2_nivel", 32'(NIVEL), 2);
        check_eq("mul2_ov", 32'(FLAG_OV), 1);
        cmd_wait(CMD_CLEAR, 8'd0);
        check_eq("clr_nivel", 32'(NIVEL), 0);
        check_eq("clr_topo", 32'(TOPO), 0);
        check_eq("clr_ov", 32'(FLAG_OV), 0);

        // Pronto already high: ignored in EMITE/GUARDA, first ESPERA completes
        stub_modo = 1; ULA_RES = 8'd77; ULA_OV = 1'b0;
        cmd_wait(CMD_PUSH, 8'd5);
        cmd_wait(CMD_PUSH, 8'd0);
        run_exec("b0", 3'b110, 4, 1);
        check_eq("b0_topo", 32'(TOPO), 77);
        check_eq("b0_nivel", 32'(NIVEL), 1);

        // underflow / overflow / swap / drop / dup
        cmd_wait(CMD_CLEAR, 8'd0);
        run_exec("vazio", 3'b100, 0, 0);
        check_eq("vazio_flag", 32'(ERRO_VAZIO), 1);
        check_eq("vazio_nivel", 32'(NIVEL), 0);
        for (int i = 1; i <= 5; i++) cmd_wait(CMD_PUSH, 8'(i));
        check_eq("cheio_flag", 32'(ERRO_CHEIO), 1);
        check_eq("cheio_nivel", 32'(NIVEL), 4);
        check_eq("cheio_topo", 32'(TOPO), 4);
        cmd_wait(CMD_SWAP, 8'd0);
        check_eq("swap_topo", 32'(TOPO), 3);
        cmd_wait(CMD_DROP, 8'd0);
        check_eq("drop_topo", 32'(TOPO), 4);
        check_eq("drop_nivel", 32'(NIVEL), 3);
        cmd_wait(CMD_DUP, 8'd0);
        check_eq("dup_topo", 32'(TOPO), 4);
        check_eq("dup_nivel", 32'(NIVEL), 4);
        cmd_wait(CMD_CLEAR, 8'd0);
        check_eq("clr_errs", {29'd0, ERRO_VAZIO, ERRO_CHEIO, ERRO_TEMPO}, 0);
        cmd_wait(CMD_DROP, 8'd0);
        check_eq("drop_vazio", 32'(ERRO_VAZIO), 1);

        // watchdog: 300 ESPERA cycles, operands kept
        stub_modo = 2;
        cmd_wait(CMD_PUSH, 8'd11);
        cmd_wait(CMD_PUSH, 8'd22);
        run_exec("tempo", 3'b100, 302, 1);
        check_eq("tempo_flag", 32'(ERRO_TEMPO), 1);
        check_eq("tempo_nivel", 32'(NIVEL), 2);
        check_eq("tempo_topo", 32'(TOPO), 22);
        check_eq("tempo_ready", 32'(cmd_if.CMD_READY), 1);

        // reset while waiting in ESPERA
        cmd_wait(CMD_CLEAR, 8'd0);
        stub_modo = 0;
        cmd_wait(CMD_PUSH, 8'd1);
        cmd_wait(CMD_PUSH, 8'd2);
        do_cmd(CMD_EXEC, 3'b100, 8'd0);
        n = 0;
        @(negedge CLOCK);
        while (estado_dbg != ESPERA && n < 20) begin
            @(negedge CLOCK);
            n++;
        end
        check_eq("reach_espera", 32'(estado_dbg), 32'(ESPERA));
        RESET = 1'b0;
        #1;
        check_eq("arst_nivel", 32'(NIVEL), 0);
        check_eq("arst_topo", 32'(TOPO), 0);
        check_eq("arst_start", 32'(ULA_START), 0);
        check_eq("arst_ready", 32'(cmd_if.CMD_READY), 1);
        check_eq("arst_op", 32'(ULA_OP), 0);
        check_eq("arst_estado", 32'(estado_dbg), 32'(OCIOSO));
        @(negedge CLOCK);
        RESET = 1'b1;
        cmd_wait(CMD_PUSH, 8'd3);
        check_eq("post_rst_topo", 32'(TOPO), 3);
        check_eq("post_rst_nivel", 32'(NIVEL), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end expected end");
        $fatal(1, "bench time limit");
    end

endmodule
